mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It is the sequential companion to the single-cycle execute ALU.
- The execute stage issues MULT/MULTU/DIV/DIVU through a start/busy/done handshake; MTHI/MTLO write HI/LO directly.
- HI/LO are always visible to the datapath for MFHI/MFLO.
- The control unit stalls while the unit is busy.

Parameters:
WIDTH, 32, operand and HI/LO width (even, >= 8).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clock  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start_i  input  1  issue request, sampled in IDLE only.
op_i  input  3  operation code, from shared package.
a_i  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
b_i  input  WIDTH  rt operand (divisor / multiplier).
abort_i  input  1  pipeline flush: cancel the in-flight op.
busy_o  output  1  op in progress; the CPU must stall HI/LO consumers.
done_o  output  1  one-cycle pulse: the result is committed.
dbz_o  output  1  divide-by-zero flag, valid with done_o.
hi_o  output  WIDTH  HI register.
lo_o  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy_o=0, done_o=0, dbz_o=0, hi_o=0, lo_o=0; counter and working registers cleared.
- States: IDLE, RUN, FIX, DONE.
- IDLE, start_i=1, op MTHI/MTLO: hi_o/lo_o <= a_i at the next edge. No busy, no done_o. Stays in IDLE.
- IDLE, start_i=1, op MULT/MULTU/DIV/DIVU:
  - Latch magnitudes (signed ops: two's-complement absolute value, so |MIN| = 2^(WIDTH-1) as unsigned).
  - Latch result-sign bits. Counter <= WIDTH. Go to RUN.
- DIV/DIVU with b_i=0: go directly to DONE with dbz_o=1. HI/LO are unchanged.
- RUN: one bit per cycle for exactly WIDTH cycles.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring, with WIDTH+1-bit partial remainder.
  - Counter decrements; at 1 go to FIX.
- FIX (1 cycle):
  - Signed multiply: negate the 2*WIDTH product if the operand signs differ.
  - Signed divide: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Write HI/LO: multiply HI=product[2W-1:W], LO=product[W-1:0]; divide LO=quotient, HI=remainder. Go to DONE.
- DONE (1 cycle): done_o=1; hi_o/lo_o already show the new values. Next state IDLE.
- busy_o=1 in RUN, FIX and DONE; 0 in IDLE.
- Latency: start accepted at edge of cycle N -> RUN N+1..N+WIDTH, FIX N+WIDTH+1, done_o at cycle N+WIDTH+2. Next start can be accepted in cycle N+WIDTH+3.
- Divide-by-zero latency: done_o at cycle N+1.
- Signed MIN / -1: LO=MIN (wraps), HI=0. No flag.
- start_i while busy_o=1 is ignored, including MTHI/MTLO; the inputs are not queued.
- abort_i=1 in RUN or FIX: go to IDLE next cycle; HI/LO untouched; no done_o.
- abort_i in DONE: no effect, because the result is already committed.
- abort_i and start_i both high in IDLE: abort wins; nothing is accepted.
- Operands are registered at accept; a_i/b_i may change afterwards.
- Undefined op codes: ignored in IDLE.

Decomposition:
- Shared package mdu_defines: op codes MDU_MULT=3'b000, MDU_MULTU=3'b001, MDU_DIV=3'b010, MDU_DIVU=3'b011, MDU_MTHI=3'b100, MDU_MTLO=3'b101; state encodings IDLE/RUN/FIX/DONE.
- One sub-module, mdu_iter_core: the per-cycle shift-add / restore-subtract step (combinational, WIDTH-parametrised).
- FSM, sign handling and HI/LO registers stay in mdu_unit.

Test Plan:
- MULT a=7, b=6 accepted at cycle 0 -> busy_o 1..34, done_o at cycle 34, HI=0x00000000, LO=0x0000002A.
- MULT a=-3, b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 -> LO=0x0000000E, HI=0x00000002. DIV a=0x80000000, b=-1 -> LO=0x80000000, HI=0.
- DIVU a=5, b=0 with HI=0x11, LO=0x22 preset via MTHI/MTLO -> done_o at cycle 1, dbz_o=1, HI=0x11, LO=0x22 unchanged.
- MULT accepted, abort_i at cycle 10 -> busy_o=0 from cycle 11, no done_o, HI/LO keep their old values. A second start during busy is ignored. Simultaneous abort and start in IDLE -> not accepted.
- rst_n low mid-RUN -> immediate busy_o=0, HI=LO=0. WIDTH=8 instance: MULTU 0xFF*0xFF -> HI=0xFE, LO=0x01, done_o at cycle 10.

Source files
------------

// File: rtl/mdu_defines.sv
// Shared op codes and FSM state encodings for the multiply/divide unit.
package mdu_defines;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// One iteration of unsigned shift-add multiply or restoring divide.
module mdu_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH:0]   hi_c,
  output logic [WIDTH-1:0] lo_c
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Multiply: add multiplicand on LSB, shift product right. Divide: shift in, trial subtract.
  always_comb begin
    sum     = hi_in + (lo_in[0] ? {1'b0, opnd} : '0);
    shifted = {hi_in, lo_in[WIDTH-1]};
    diff    = shifted - {2'b00, opnd};
    hi_c    = {1'b0, sum[WIDTH:1]};
    lo_c    = {sum[0], lo_in[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        hi_c = diff[WIDTH:0];
        lo_c = {lo_in[WIDTH-2:0], 1'b1};
      end else begin
        hi_c = shifted[WIDTH:0];
        lo_c = {lo_in[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
module mdu_unit
  import mdu_defines::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned PW    = 2 * WIDTH;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q, opnd_q;
  logic             is_div_q, neg_res_q, neg_rem_q;

  logic             op_md, op_div, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             accept_run, dbz_d, wr_mthi, wr_mtlo;
  logic [WIDTH:0]   core_hi;
  logic [WIDTH-1:0] core_lo;
  logic [PW-1:0]    prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix, fix_hi, fix_lo;

  // Operand decode and magnitudes for signed ops.
  always_comb begin
    op_div    = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
    op_md     = op_div || (op_i == MDU_MULT) || (op_i == MDU_MULTU);
    op_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
    a_neg     = op_signed & a_i[WIDTH-1];
    b_neg     = op_signed & b_i[WIDTH-1];
    a_mag     = a_neg ? WIDTH'(-a_i) : a_i;
    b_mag     = b_neg ? WIDTH'(-b_i) : b_i;
  end

  // Next-state and accept decode.
  always_comb begin
    state_d    = state_q;
    accept_run = 1'b0;
    dbz_d      = 1'b0;
    wr_mthi    = 1'b0;
    wr_mtlo    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          if (op_md) begin
            if (op_div && (b_i == '0)) begin
              state_d = DONE;
              dbz_d   = 1'b1;
            end else begin
              state_d    = RUN;
              accept_run = 1'b1;
            end
          end else begin
            wr_mthi = (op_i == MDU_MTHI);
            wr_mtlo = (op_i == MDU_MTLO);
          end
        end
      end
      RUN: begin
        if (abort_i)                    state_d = IDLE;
        else if (cnt_q == CNT_W'(1))    state_d = FIX;
      end
      FIX:     state_d = abort_i ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      dbz_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_o  <= (state_d != IDLE);
      done_o  <= (state_d == DONE);
      dbz_o   <= dbz_d;
    end
  end

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .is_div (is_div_q),
    .hi_in  (acc_hi_q),
    .lo_in  (acc_lo_q),
    .opnd   (opnd_q),
    .hi_c   (core_hi),
    .lo_c   (core_lo)
  );

  // Sign fix-up of the unsigned result.
  always_comb begin
    prod     = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    prod_fix = neg_res_q ? PW'(-prod) : prod;
    q_fix    = neg_res_q ? WIDTH'(-acc_lo_q) : acc_lo_q;
    r_fix    = neg_rem_q ? WIDTH'(-acc_hi_q[WIDTH-1:0]) : acc_hi_q[WIDTH-1:0];
    fix_hi   = is_div_q ? r_fix : prod_fix[PW-1:WIDTH];
    fix_lo   = is_div_q ? q_fix : prod_fix[WIDTH-1:0];
  end

  // Working registers, iteration counter and HI/LO.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_o      <= '0;
      lo_o      <= '0;
    end else begin
      if (accept_run) begin
        cnt_q     <= CNT_W'(WIDTH);
        acc_hi_q  <= '0;
        acc_lo_q  <= op_div ? a_mag : b_mag;
        opnd_q    <= op_div ? b_mag : a_mag;
        is_div_q  <= op_div;
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= op_div & a_neg;
      end else if (state_q == RUN) begin
        cnt_q    <= cnt_q - CNT_W'(1);
        acc_hi_q <= core_hi;
        acc_lo_q <= core_lo;
      end
      if ((state_q == FIX) && !abort_i) begin
        hi_o <= fix_hi;
        lo_o <= fix_lo;
      end
      if (wr_mthi) hi_o <= a_i;
      if (wr_mtlo) lo_o <= a_i;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: vector table, scoreboard and corner sequences.
module tb_mdu_unit;
  import mdu_defines::*;

  localparam int unsigned W = 32;

  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  logic          start, abort, busy, done, dbz;
  logic [2:0]    op_s;
  logic [W-1:0]  a_s, b_s, hi, lo;

  logic          s8, abort8, busy8, done8, dbz8;
  logic [2:0]    op8;
  logic [7:0]    a8, b8, hi8, lo8;

  mdu_unit #(.WIDTH(W)) u_dut (
    .clock(clock), .rst_n(rst_n), .start_i(start), .op_i(op_s), .a_i(a_s), .b_i(b_s),
    .abort_i(abort), .busy_o(busy), .done_o(done), .dbz_o(dbz), .hi_o(hi), .lo_o(lo)
  );

  mdu_unit #(.WIDTH(8)) u_dut8 (
    .clock(clock), .rst_n(rst_n), .start_i(s8), .op_i(op8), .a_i(a8), .b_i(b8),
    .abort_i(abort8), .busy_o(busy8), .done_o(done8), .dbz_o(dbz8), .hi_o(hi8), .lo_o(lo8)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dbz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi, lo;
    logic         dbz;
    int           lat;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op on the 32-bit unit, then retire it against the scoreboard.
  task automatic run32(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] hi_e, input logic [W-1:0] lo_e, input logic dbz_e,
                       input string name);
    exp_t e, got;
    int   cyc;
    e.hi = hi_e; e.lo = lo_e; e.dbz = dbz_e; e.name = name;
    e.lat = dbz_e ? 1 : int'(W) + 2;
    @(negedge clock);
    start = 1'b1; op_s = op; a_s = a; b_s = b;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0; a_s = $urandom(); b_s = $urandom();
    cyc = 1;
    check({name, "_busy"}, 64'(busy), 64'(1));
    while (!done && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    got = sb.pop_front();
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no done_o after %0d cycles", got.name, cyc);
    end else begin
      check({got.name, "_lat"}, 64'(cyc), 64'(got.lat));
      check({got.name, "_hi"}, 64'(hi), 64'(got.hi));
      check({got.name, "_lo"}, 64'(lo), 64'(got.lo));
      check({got.name, "_dbz"}, 64'(dbz), 64'(got.dbz));
    end
    @(negedge clock);
    check({got.name, "_after"}, 64'({busy, done, dbz}), 64'(0));
  endtask

  // Drive an MTHI/MTLO for one cycle.
  task automatic mt32(input logic [2:0] op, input logic [W-1:0] d);
    @(negedge clock);
    start = 1'b1; op_s = op; a_s = d;
    @(negedge clock);
    start = 1'b0;
  endtask

  vec_t vecs[9];
  int   ndone, cyc;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_s = '0; a_s = '0; b_s = '0;
    s8 = 1'b0; abort8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;

    vecs[0] = '{MDU_MULT,  32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A, 1'b0};
    vecs[1] = '{MDU_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[3] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{MDU_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[5] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

    repeat (2) @(negedge clock);
    check("reset_state", 64'({busy, done, dbz}), 64'(0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz,
            $sformatf("vec%0d", i));

    // MTHI/MTLO: direct write, no busy, no done.
    mt32(MDU_MTHI, 32'h11);
    check("mthi_busy", 64'({busy, done}), 64'(0));
    check("mthi_hi", 64'(hi), 64'h11);
    mt32(MDU_MTLO, 32'h22);
    check("mtlo_lo", 64'(lo), 64'h22);

    // Divide by zero leaves HI/LO alone.
    run32(MDU_DIVU, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, "dbz");

    // Abort mid-run with an ignored start while busy.
    ndone = 0;
    @(negedge clock);
    start = 1'b1; op_s = MDU_MULT; a_s = 32'd7; b_s = 32'd6;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clock);
      start = 1'b0; abort = 1'b0;
      if (done) ndone++;
      if (c == 3) begin start = 1'b1; op_s = MDU_MTHI; a_s = 32'h99; end
      if (c == 10) abort = 1'b1;
    end
    check("abort_busy", 64'(busy), 64'(0));
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done || busy) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'(0));
    check("abort_hi", 64'(hi), 64'h11);
    check("abort_lo", 64'(lo), 64'h22);

    // Abort and start together in IDLE: nothing accepted.
    @(negedge clock);
    start = 1'b1; abort = 1'b1; op_s = MDU_MULT; a_s = 32'd3; b_s = 32'd3;
    @(negedge clock);
    check("abort_start_busy", 64'(busy), 64'(0));
    op_s = MDU_MTHI; a_s = 32'h77;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    check("abort_mthi", 64'(hi), 64'h11);

    // Narrow instance.
    @(negedge clock);
    s8 = 1'b1; op8 = MDU_MULTU; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clock);
    s8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    cyc = 1;
    while (!done8 && cyc < 50) begin @(negedge clock); cyc++; end
    check("w8_multu_lat", 64'(cyc), 64'(10));
    check("w8_multu_hi", 64'(hi8), 64'hFE);
    check("w8_multu_lo", 64'(lo8), 64'h01);
    @(negedge clock);
    s8 = 1'b1; op8 = MDU_DIV; a8 = 8'h80; b8 = 8'hFF;
    @(negedge clock);
    s8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 50) begin @(negedge clock); cyc++; end
    check("w8_div_lat", 64'(cyc), 64'(10));
    check("w8_div_hi", 64'(hi8), 64'h00);
    check("w8_div_lo", 64'(lo8), 64'h80);

    // Asynchronous reset in the middle of a run.
    @(negedge clock);
    start = 1'b1; op_s = MDU_MULT; a_s = 32'd7; b_s = 32'd6;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    check("pre_reset_busy", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", 64'(busy), 64'(0));
    check("midrun_reset_hilo", {hi, lo}, 64'(0));
    @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
